// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: op codes, FSM states, flag positions
// and op classification helpers.
package alu_sched_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOT = 4'b0101;
  localparam logic [3:0] ALU_LSA = 4'b0110;
  localparam logic [3:0] ALU_RSA = 4'b0111;
  localparam logic [3:0] ALU_LSL = 4'b1000;
  localparam logic [3:0] ALU_RSL = 4'b1001;
  localparam logic [3:0] ALU_DIV = 4'b1010;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op >= ALU_LSA) && (op <= ALU_RSL);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= ALU_DIV;
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response and ALU bus between the two requesters, the scheduler and the ALU.
// The master side is the requester/ALU environment, the slave side is the scheduler.
interface alu_scheduler_if #(
  parameter int N   = 32,
  parameter int SHW = 5
);
  logic           req0_valid;
  logic           req0_ready;
  logic [N-1:0]   req0_a;
  logic [N-1:0]   req0_b;
  logic [3:0]     req0_op;
  logic [SHW-1:0] req0_shamt;

  logic           req1_valid;
  logic           req1_ready;
  logic [N-1:0]   req1_a;
  logic [N-1:0]   req1_b;
  logic [3:0]     req1_op;
  logic [SHW-1:0] req1_shamt;

  logic           rsp0_valid;
  logic           rsp1_valid;
  logic [N-1:0]   rsp_result;
  logic [3:0]     rsp_flags;

  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [3:0]     alu_ctrl;
  logic [N-1:0]   alu_result;
  logic [3:0]     alu_flags;

  logic           busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_shamt,
    output req1_valid, req1_a, req1_b, req1_op, req1_shamt,
    output alu_result, alu_flags,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
    input  alu_a, alu_b, alu_ctrl, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_shamt,
    input  req1_valid, req1_a, req1_b, req1_op, req1_shamt,
    input  alu_result, alu_flags,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
    output alu_a, alu_b, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_scheduler_arb.sv
// Two-way round-robin arbiter; after each accepted grant the pointer moves to the
// requester that was not granted, so a waiting requester always wins next.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (&req) grant = ptr ? 2'b10 : 2'b01;
      else      grant = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters, sequencing multi-bit shifts
// as repeated single-bit ALU steps and returning result/flags to the owner.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input logic            clk,
  input logic            rst_n,
  alu_scheduler_if.slave bus
);

  state_t         state, next_state;
  logic [N-1:0]   a_r, b_r, res_r;
  logic [3:0]     op_r, flg_r;
  logic [SHW-1:0] cnt;
  logic           owner;

  logic [1:0]     grant;
  logic           accept, sel;
  logic [N-1:0]   in_a, in_b;
  logic [3:0]     in_op;
  logic [SHW-1:0] in_shamt;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .en      (state == IDLE),
    .advance (accept),
    .grant   (grant)
  );

  assign accept         = |grant;
  assign sel            = grant[1];
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign in_a     = sel ? bus.req1_a     : bus.req0_a;
  assign in_b     = sel ? bus.req1_b     : bus.req0_b;
  assign in_op    = sel ? bus.req1_op    : bus.req0_op;
  assign in_shamt = sel ? bus.req1_shamt : bus.req0_shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_legal(in_op))                            next_state = DONE;
          else if (is_shift(in_op) && in_shamt == '0)      next_state = DONE;
          else if (is_shift(in_op))                        next_state = SHIFT;
          else                                             next_state = EXEC;
        end
      end
      EXEC:    next_state = DONE;
      SHIFT:   if (cnt == SHW'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Zero-length shifts and illegal ops resolve at accept time and skip the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      cnt   <= '0;
      owner <= 1'b0;
      res_r <= '0;
      flg_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= in_a;
            b_r   <= in_b;
            op_r  <= in_op;
            cnt   <= in_shamt;
            owner <= sel;
            if (!is_legal(in_op)) begin
              res_r <= '0;
              flg_r <= '0;
            end else if (is_shift(in_op) && in_shamt == '0) begin
              res_r <= in_a;
              flg_r <= {in_a == '0, in_a[N-1], 2'b00};
            end
          end
        end
        EXEC: begin
          res_r <= bus.alu_result;
          flg_r <= bus.alu_flags;
        end
        SHIFT: begin
          a_r <= bus.alu_result;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            res_r <= bus.alu_result;
            flg_r <= bus.alu_flags;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp_result = '0;
    bus.rsp_flags  = '0;
    bus.busy       = (state != IDLE);
    if (state == DONE) begin
      bus.rsp0_valid = !owner;
      bus.rsp1_valid = owner;
      bus.rsp_result = res_r;
      bus.rsp_flags  = flg_r;
    end
  end

  assign bus.alu_a    = a_r;
  assign bus.alu_b    = b_r;
  assign bus.alu_ctrl = op_r;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: two requester drivers, a behavioural ALU,
// a reference model computing whole operations directly, and a response monitor.
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  localparam int N   = 32;
  localparam int SHW = 5;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
  } txn_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   ptr_model = 0;

  txn_t stim0[$], stim1[$];
  exp_t sb0[$], sb1[$];
  txn_t cur0, cur1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_scheduler_if #(.N(N), .SHW(SHW)) bus ();

  alu_scheduler #(.N(N), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [35:0] alu_step(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    logic        c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin {c, r} = 33'(a) + 33'(b); v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOT: r = ~a;
      ALU_LSA, ALU_LSL: begin r = a << 1; c = a[31]; end
      ALU_RSA: begin r = 32'($signed(a) >>> 1); c = a[0]; end
      ALU_RSL: begin r = a >> 1; c = a[0]; end
      ALU_DIV: r = (b == 0) ? 32'd0 : a / b;
      default: ;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  always_comb {bus.alu_result, bus.alu_flags} = alu_step(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  // Whole-operation model: shifts by k are computed in one go, due is the latency.
  function automatic exp_t ref_model(txn_t t);
    exp_t        e;
    logic [31:0] r;
    logic        c;
    int          k;
    k = int'(t.shamt);
    if (!is_legal(t.op)) begin
      e = '{res: 32'd0, flags: 4'd0, due: 1};
    end else if (is_shift(t.op) && k == 0) begin
      e = '{res: t.a, flags: {t.a == 32'd0, t.a[31], 2'b00}, due: 1};
    end else if (is_shift(t.op)) begin
      if (t.op == ALU_LSA || t.op == ALU_LSL) begin
        r = t.a << k;
        c = t.a[32-k];
      end else begin
        r = (t.op == ALU_RSA) ? 32'($signed(t.a) >>> k) : (t.a >> k);
        c = t.a[k-1];
      end
      e = '{res: r, flags: {r == 32'd0, r[31], c, 1'b0}, due: k + 1};
    end else begin
      {e.res, e.flags} = alu_step(t.op, t.a, t.b);
      e.due = 2;
    end
    return e;
  endfunction

  function automatic txn_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    txn_t t;
    t.op = op; t.a = a; t.b = b; t.shamt = sh;
    return t;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(int r, txn_t t);
    if (r == 0) stim0.push_back(t);
    else        stim1.push_back(t);
  endtask

  task automatic checkReset(string tag);
    checkOutput({tag, "_alu_a"}, bus.alu_a, 32'd0);
    checkOutput({tag, "_alu_b"}, bus.alu_b, 32'd0);
    checkOutput({tag, "_alu_ctrl"}, 32'(bus.alu_ctrl), 32'd0);
    checkOutput({tag, "_rsp_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    checkOutput({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
    checkOutput({tag, "_rsp_flags"}, 32'(bus.rsp_flags), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic waitDrain(int budget);
    int n = 0;
    while ((stim0.size() != 0 || stim1.size() != 0 || sb0.size() != 0 || sb1.size() != 0 ||
            bus.req0_valid || bus.req1_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: pending %0d/%0d/%0d/%0d required 0",
               stim0.size(), stim1.size(), sb0.size(), sb1.size());
    end
    @(negedge clk);
    #2;
  endtask

  // Requester 0 driver: present at negedge, detect handshake just before posedge.
  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req0_shamt = '0;
    forever begin
      @(negedge clk);
      if (!bus.req0_valid && stim0.size() != 0 && rst_n) begin
        cur0 = stim0.pop_front();
        bus.req0_a = cur0.a; bus.req0_b = cur0.b; bus.req0_op = cur0.op; bus.req0_shamt = cur0.shamt;
        bus.req0_valid = 1'b1;
      end
      #1;
      if (bus.req0_valid && bus.req0_ready) begin
        exp_t e;
        e = ref_model(cur0);
        e.due += cyc;
        sb0.push_back(e);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req0_op = 4'($urandom); bus.req0_shamt = 5'($urandom);
      end
    end
  end

  initial begin
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.req1_shamt = '0;
    forever begin
      @(negedge clk);
      if (!bus.req1_valid && stim1.size() != 0 && rst_n) begin
        cur1 = stim1.pop_front();
        bus.req1_a = cur1.a; bus.req1_b = cur1.b; bus.req1_op = cur1.op; bus.req1_shamt = cur1.shamt;
        bus.req1_valid = 1'b1;
      end
      #1;
      if (bus.req1_valid && bus.req1_ready) begin
        exp_t e;
        e = ref_model(cur1);
        e.due += cyc;
        sb1.push_back(e);
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        bus.req1_a = $urandom; bus.req1_b = $urandom;
        bus.req1_op = 4'($urandom); bus.req1_shamt = 5'($urandom);
      end
    end
  end

  // Round-robin model: with both requesting, the one not served last must win.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        ptr_model = 0;
      end else begin
        checkOutput("dual_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        if (bus.req0_valid && bus.req1_valid && (bus.req0_ready || bus.req1_ready))
          checkOutput("rr_grant", 32'(bus.req1_ready), 32'(ptr_model));
        if (bus.req0_valid && bus.req0_ready)      ptr_model = 1;
        else if (bus.req1_valid && bus.req1_ready) ptr_model = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.rsp0_valid) begin
        if (sb0.size() == 0) checkOutput("rsp0_unexpected", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb0.pop_front();
          checkOutput("rsp0_result", bus.rsp_result, e.res);
          checkOutput("rsp0_flags", 32'(bus.rsp_flags), 32'(e.flags));
          checkOutput("rsp0_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (bus.rsp1_valid) begin
        if (sb1.size() == 0) checkOutput("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb1.pop_front();
          checkOutput("rsp1_result", bus.rsp_result, e.res);
          checkOutput("rsp1_flags", 32'(bus.rsp_flags), 32'(e.flags));
          checkOutput("rsp1_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkReset("por");
    rst_n = 1'b1;

    applyStimulus(0, mk(ALU_SUB, 32'd3, 32'd3, 5'd0));
    applyStimulus(1, mk(ALU_OR, 32'hF0, 32'h0F, 5'd0));
    applyStimulus(0, mk(ALU_SUB, 32'd3, 32'd3, 5'd0));
    applyStimulus(1, mk(ALU_OR, 32'hF0, 32'h0F, 5'd0));
    waitDrain(200);

    applyStimulus(0, mk(ALU_ADD, 32'd5, 32'd7, 5'd0));
    applyStimulus(0, mk(ALU_RSA, 32'h8000_0000, 32'd0, 5'd4));
    applyStimulus(0, mk(ALU_RSA, 32'h8000_0000, 32'd0, 5'd0));
    applyStimulus(0, mk(4'b1101, 32'd9, 32'd9, 5'd3));
    applyStimulus(1, mk(ALU_LSL, 32'd1, 32'd0, 5'd31));
    applyStimulus(1, mk(ALU_DIV, 32'd100, 32'd7, 5'd0));
    waitDrain(400);

    applyStimulus(1, mk(ALU_LSL, 32'd1, 32'd0, 5'd31));
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.busy && w < 50);
    checkOutput("shift_started", 32'(bus.busy), 32'd1);
    repeat (21) begin
      @(negedge clk);
      checkOutput("shift_ctrl", 32'(bus.alu_ctrl), 32'(ALU_LSL));
    end
    #2;
    rst_n = 1'b0;
    sb1.delete();
    #1;
    checkReset("mid_reset");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1, mk(ALU_ADD, 32'd100, 32'd23, 5'd0));
    waitDrain(200);

    for (int i = 0; i < 60; i++) begin
      txn_t t;
      t.op    = 4'($urandom_range(0, 15));
      t.a     = $urandom;
      t.b     = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      t.shamt = 5'($urandom_range(0, 31));
      applyStimulus(int'($urandom_range(0, 1)), t);
    end
    waitDrain(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
